// File: rtl/png_pkg.sv
// PNG chunk sequencer shared definitions: FSM states, chunk type codes, CRC-32 helpers.
// Contents: state_t enum, CHK_* type constants, crc32_byte() byte-step, byte_sel() MSB-first byte pick.
// Imported by the chunk controller, its crc32 engine, and the bench.
package png_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        TYPE,
        DATA,
        CRC_WAIT,
        CRC,
        DONE
    } state_t;

    localparam logic [31:0] CHK_IHDR = 32'h49484452;
    localparam logic [31:0] CHK_IDAT = 32'h49444154;
    localparam logic [31:0] CHK_IEND = 32'h49454E44;

    // Reflected IEEE 802.3 polynomial, as used by PNG/zlib.
    localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    // Advance a running (non-inverted) CRC-32 by one byte, LSB-first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Byte idx of a 32-bit word, idx 0 = bits [31:24] (big-endian wire order).
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] r;
        case (idx)
            2'd0:    r = w[31:24];
            2'd1:    r = w[23:16];
            2'd2:    r = w[15:8];
            default: r = w[7:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/png_chunk_ctrl_if.sv
// Chunk controller bus: start/len/type command, payload byte input, output byte stream, status.
// Ports: master = producer/writer side (drives command, payload, rdy_i); slave = controller.
// Payload and output streams are valid/ready; busy_o/done_o report chunk progress.
interface png_chunk_ctrl_if #(
    parameter int LEN_WD = 32
);
    logic              start_i;
    logic [LEN_WD-1:0] len_i;
    logic [31:0]       type_i;
    logic              dat_val_i;
    logic [7:0]        dat_i;
    logic              dat_rdy_o;
    logic              val_o;
    logic [7:0]        dat_o;
    logic              rdy_i;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, len_i, type_i, dat_val_i, dat_i, rdy_i,
        input  dat_rdy_o, val_o, dat_o, busy_o, done_o
    );

    modport slave (
        input  start_i, len_i, type_i, dat_val_i, dat_i, rdy_i,
        output dat_rdy_o, val_o, dat_o, busy_o, done_o
    );
endinterface

// File: rtl/png_chunk_ctrl_crc32.sv
// Byte-serial PNG CRC-32 engine: start_i re-seeds, val_i folds dat_i, lst_i closes the checksum.
// Ports: clk, rst, start_i, val_i, dat_i, lst_i in; val_o (1-cycle pulse), dat_o (final CRC) out.
// Latency: result valid the cycle after the byte carrying lst_i; accepts one byte per cycle.
module png_chunk_ctrl_crc32
    import png_pkg::*;
#(
    parameter int CRC_WD = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              val_i,
    input  logic [7:0]        dat_i,
    input  logic              lst_i,
    output logic              val_o,
    output logic [CRC_WD-1:0] dat_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_nxt;

    assign crc_nxt = crc32_byte(crc_q, dat_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC32_INIT;
            val_o <= 1'b0;
            dat_o <= '0;
        end else begin
            val_o <= 1'b0;
            if (start_i) begin
                crc_q <= CRC32_INIT;
            end else if (val_i) begin
                crc_q <= crc_nxt;
                if (lst_i) begin
                    val_o <= 1'b1;
                    dat_o <= CRC_WD'(~crc_nxt);
                end
            end
        end
    end

endmodule

// File: rtl/png_chunk_ctrl.sv
// Serialises one PNG chunk: LENGTH(4B BE), TYPE(4B), DATA(N B pass-through), CRC(4B BE).
// Ports: clk, rst (sync, active-high); bus (slave modport) carries command, payload and output stream.
// rdy_i low stalls every state with dat_o held; payload ready is rdy_i itself while in DATA.
module png_chunk_ctrl
    import png_pkg::*;
#(
    parameter int LEN_WD = 32,
    parameter int CRC_WD = 32
) (
    input  logic              clk,
    input  logic              rst,
    png_chunk_ctrl_if.slave   bus
);

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [LEN_WD-1:0]   dcnt_q, dcnt_d;
    logic [LEN_WD-1:0]   len_q;
    logic [31:0]         type_q;
    logic [CRC_WD-1:0]   crc_q;

    logic                crc_start;
    logic                crc_val;
    logic [7:0]          crc_dat;
    logic                crc_lst;
    logic                crc_res_val;
    logic [CRC_WD-1:0]   crc_res;

    png_chunk_ctrl_crc32 #(.CRC_WD(CRC_WD)) u_crc32 (
        .clk     (clk),
        .rst     (rst),
        .start_i (crc_start),
        .val_i   (crc_val),
        .dat_i   (crc_dat),
        .lst_i   (crc_lst),
        .val_o   (crc_res_val),
        .dat_o   (crc_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            len_q   <= '0;
            type_q  <= '0;
            crc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            if (state_q == IDLE && bus.start_i) begin
                len_q  <= bus.len_i;
                type_q <= bus.type_i;
            end
            if (state_q == CRC_WAIT && crc_res_val) begin
                crc_q <= crc_res;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dcnt_d        = dcnt_q;
        bus.val_o     = 1'b0;
        bus.dat_o     = 8'd0;
        bus.dat_rdy_o = 1'b0;
        bus.done_o    = 1'b0;
        bus.busy_o    = (state_q != IDLE);
        crc_start     = 1'b0;
        crc_val       = 1'b0;
        crc_dat       = 8'd0;
        crc_lst       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    crc_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = LEN;
                end
            end
            LEN: begin
                bus.val_o = 1'b1;
                bus.dat_o = byte_sel(32'(len_q), cnt_q);
                if (bus.rdy_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = TYPE;
                end
            end
            TYPE: begin
                bus.val_o = 1'b1;
                bus.dat_o = byte_sel(type_q, cnt_q);
                if (bus.rdy_i) begin
                    crc_val = 1'b1;
                    crc_dat = bus.dat_o;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Empty chunk: the CRC closes on the last type byte.
                        crc_lst = (len_q == '0);
                        dcnt_d  = len_q;
                        state_d = (len_q == '0) ? CRC_WAIT : DATA;
                    end
                end
            end
            DATA: begin
                bus.val_o     = bus.dat_val_i;
                bus.dat_o     = bus.dat_i;
                bus.dat_rdy_o = bus.rdy_i;
                if (bus.dat_val_i && bus.rdy_i) begin
                    crc_val = 1'b1;
                    crc_dat = bus.dat_i;
                    dcnt_d  = dcnt_q - LEN_WD'(1);
                    if (dcnt_q == LEN_WD'(1)) begin
                        crc_lst = 1'b1;
                        state_d = CRC_WAIT;
                    end
                end
            end
            CRC_WAIT: begin
                if (crc_res_val) begin
                    cnt_d   = '0;
                    state_d = CRC;
                end
            end
            CRC: begin
                bus.val_o = 1'b1;
                bus.dat_o = byte_sel(32'(crc_q), cnt_q);
                if (bus.rdy_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = DONE;
                end
            end
            DONE: begin
                bus.done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_png_chunk_ctrl.sv
module tb_png_chunk_ctrl;
    import png_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    png_chunk_ctrl_if #(.LEN_WD(32)) bus ();

    png_chunk_ctrl #(.LEN_WD(32), .CRC_WD(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] pay[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];

    int  cyc = 0;
    int  n_crc_val, n_lst, lst_at, done_cnt, done_cyc, last_xfer_cyc, stall_err;
    bit  held;
    logic [7:0] held_dat;
    bit  timed_out;

    // Passive monitor: collects transferred bytes and crc32 feed activity.
    always @(negedge clk) begin
        cyc++;
        if (bus.val_o && bus.rdy_i) begin
            got.push_back(bus.dat_o);
            last_xfer_cyc = cyc;
        end
        if (dut.crc_val) begin
            n_crc_val++;
            if (dut.crc_lst) begin
                n_lst++;
                lst_at = n_crc_val;
            end
        end
        if (bus.done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (held && bus.val_o && bus.dat_o !== held_dat) stall_err++;
        held     = bus.val_o && !bus.rdy_i;
        held_dat = bus.dat_o;
    end

    task automatic clear_mon();
        got.delete();
        n_crc_val = 0; n_lst = 0; lst_at = 0; done_cnt = 0;
        done_cyc = 0; last_xfer_cyc = 0; stall_err = 0; held = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
    endtask

    // Drives one chunk; abort_idx >= 0 raises rst while that payload byte is offered.
    task automatic run_chunk(input logic [31:0] typ, input logic [31:0] len, input bit rdy_rand,
                             input int gap, input int spur_cyc, input int abort_idx);
        int  idx, gap_left;
        bit  done_seen, acc, aborted;
        @(posedge clk); #1;
        clear_mon();
        timed_out = 1'b0;
        bus.start_i = 1'b1; bus.len_i = len; bus.type_i = typ; bus.rdy_i = 1'b1;
        bus.dat_val_i = 1'b0;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        idx = 0; gap_left = 0; done_seen = 1'b0; aborted = 1'b0;
        for (int c = 0; c < 600 && !done_seen && !aborted; c++) begin
            bus.start_i = (c == spur_cyc);
            if (c == spur_cyc) begin
                bus.len_i  = 32'd0;
                bus.type_i = CHK_IEND;
            end
            bus.rdy_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!bus.dat_val_i) begin
                if (gap_left > 0) gap_left--;
                else if (idx < int'(len)) begin
                    bus.dat_val_i = 1'b1;
                    bus.dat_i     = pay[idx];
                end
            end
            if (abort_idx >= 0 && idx == abort_idx && bus.dat_val_i) begin
                rst = 1'b1;
                aborted = 1'b1;
            end else begin
                @(negedge clk);
                acc = bus.dat_val_i && bus.dat_rdy_o;
                if (acc) idx++;
                if (bus.done_o) done_seen = 1'b1;
                @(posedge clk); #1;
                if (acc) begin
                    bus.dat_val_i = 1'b0;
                    gap_left = gap;
                end
            end
        end
        bus.start_i = 1'b0;
        if (!aborted) begin
            tests_run++;
            if (!done_seen) begin
                tests_failed++;
                timed_out = 1'b1;
                $display("FAIL chunk_timeout: done_o seen %0d, required 1", done_seen);
            end
            bus.rdy_i = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0; bus.len_i = 32'd0; bus.type_i = 32'd0;
        bus.dat_val_i = 1'b1; bus.dat_i = 8'hA5; bus.rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus.val_o, bus.dat_o, bus.dat_rdy_o, bus.busy_o, bus.done_o} !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: val=%b dat=%02h rdy=%b busy=%b done=%b, required all 0",
                     bus.val_o, bus.dat_o, bus.dat_rdy_o, bus.busy_o, bus.done_o);
        end
        tests_run++;
        if ({dut.crc_start, dut.crc_val, dut.crc_lst} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_crc_ctl: start/val/lst=%b%b%b, required 000",
                     dut.crc_start, dut.crc_val, dut.crc_lst);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.dat_val_i = 1'b0;
    endtask

    task automatic test_iend(input string nm);
        pay.delete(); exp_q.delete();
        push_word(32'h00000000); push_word(CHK_IEND); push_word(32'hAE426082);
        run_chunk(CHK_IEND, 32'd0, 1'b0, 0, -1, -1);
        tests_run++;
        if (got.size() !== 12) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d bytes, required 12", nm, got.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s_byte%0d: got %02h, required %02h", nm, i, got[i], exp_q[i]);
            end
        end
        tests_run++;
        if (n_crc_val !== 4 || lst_at !== 4 || n_lst !== 1) begin
            tests_failed++;
            $display("FAIL %s_crc_feed: val %0d lst %0d at %0d, required 4 1 4", nm, n_crc_val, n_lst, lst_at);
        end
        tests_run++;
        if (done_cnt !== 1 || done_cyc - last_xfer_cyc !== 1) begin
            tests_failed++;
            $display("FAIL %s_done: pulses %0d delay %0d, required 1 1", nm, done_cnt, done_cyc - last_xfer_cyc);
        end
        tests_run++;
        if (bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_busy_after: got %b, required 0", nm, bus.busy_o);
        end
    endtask

    task automatic load_ihdr();
        logic [7:0] p[13] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
                               8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        pay.delete(); exp_q.delete();
        foreach (p[i]) pay.push_back(p[i]);
        push_word(32'd13); push_word(CHK_IHDR);
        foreach (p[i]) exp_q.push_back(p[i]);
        push_word(32'h3A7E9B55);
    endtask

    task automatic test_ihdr(input string nm, input bit rdy_rand, input int spur);
        load_ihdr();
        run_chunk(CHK_IHDR, 32'd13, rdy_rand, 0, spur, -1);
        tests_run++;
        if (got.size() !== 25) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d bytes, required 25", nm, got.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s_byte%0d: got %02h, required %02h", nm, i, got[i], exp_q[i]);
            end
        end
        tests_run++;
        if (stall_err !== 0 || n_crc_val !== 17 || lst_at !== 17) begin
            tests_failed++;
            $display("FAIL %s_stall_crc: unstable %0d feeds %0d lst_at %0d, required 0 17 17",
                     nm, stall_err, n_crc_val, lst_at);
        end
    endtask

    task automatic test_idat_gaps();
        pay.delete(); exp_q.delete();
        pay.push_back(8'h78); pay.push_back(8'h9C); pay.push_back(8'h63);
        push_word(32'd3); push_word(CHK_IDAT);
        foreach (pay[i]) exp_q.push_back(pay[i]);
        run_chunk(CHK_IDAT, 32'd3, 1'b0, 2, -1, -1);
        tests_run++;
        if (got.size() !== 15) begin
            tests_failed++;
            $display("FAIL idat_count: got %0d bytes, required 15", got.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            tests_run++;
            if (got[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL idat_byte%0d: got %02h, required %02h", i, got[i], exp_q[i]);
            end
        end
        tests_run++;
        if (n_crc_val !== 7 || n_lst !== 1 || lst_at !== 7) begin
            tests_failed++;
            $display("FAIL idat_crc_feed: val %0d lst %0d at %0d, required 7 1 7", n_crc_val, n_lst, lst_at);
        end
    endtask

    task automatic test_rst_mid();
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(8'(8'h10 + i));
        run_chunk(CHK_IDAT, 32'd10, 1'b0, 0, -1, 4);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.val_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_abort: val=%b busy=%b, required 0 0", bus.val_o, bus.busy_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.dat_val_i = 1'b0;
        test_iend("rst_iend");
    endtask

    initial begin
        bus.start_i = 1'b0; bus.len_i = '0; bus.type_i = '0;
        bus.dat_val_i = 1'b0; bus.dat_i = '0; bus.rdy_i = 1'b0;
        clear_mon();
        test_reset();
        test_iend("iend");
        test_ihdr("ihdr", 1'b0, -1);
        test_ihdr("ihdr_bp", 1'b1, -1);
        test_idat_gaps();
        test_rst_mid();
        test_ihdr("spur_start", 1'b0, 6);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
